// File: rtl/stopwatch_core.sv
// stopwatch_core: 10 ms prescaler, centisecond/second/minute counter and start/stop/clear/lap FSM.
// Define STOPWATCH_LAP_EN to build the LAP state, the lap register and the frozen-display mux.
module stopwatch_core #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ss,
  input  logic       clr,
  input  logic       lap,
  output logic [6:0] sms,
  output logic [6:0] s,
  output logic [6:0] m,
  output logic       running,
  output logic       lap_act,
  output logic       ovf
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t        state;
  logic          ss_q, clr_q;
  logic          ss_ev, clr_ev;
  logic          do_ss, do_clr;
  logic          counting, tick, wrap;
  logic [PW-1:0] presc;
  logic [6:0]    cs, sec, min;
  logic [6:0]    adv_cs, adv_sec, adv_min;

`ifdef STOPWATCH_LAP_EN
  logic          lap_q;
  logic          do_lap;
  logic [6:0]    lap_cs, lap_sec, lap_min;
`else
  logic          lap_unused;

  assign lap_unused = lap;
  assign lap_act    = 1'b0;
`endif

  // Event arbitration (clr beats ss beats lap) and the live count one tick ahead.
  always_comb begin
    ss_ev  = ss & ~ss_q;
    clr_ev = clr & ~clr_q;
    do_clr = clr_ev;
    do_ss  = ss_ev & ~clr_ev;
`ifdef STOPWATCH_LAP_EN
    do_lap   = lap & ~lap_q & ~ss_ev & ~clr_ev;
    counting = (state == RUN) || (state == LAP);
`else
    counting = (state == RUN);
`endif
    tick    = counting && (presc == PRESC_MAX);
    wrap    = 1'b0;
    adv_cs  = cs;
    adv_sec = sec;
    adv_min = min;
    if (tick) begin
      if (cs != 7'd99) begin
        adv_cs = cs + 7'd1;
      end else begin
        adv_cs = '0;
        if (sec != 7'd59) begin
          adv_sec = sec + 7'd1;
        end else begin
          adv_sec = '0;
          if (min != 7'd99) begin
            adv_min = min + 7'd1;
          end else begin
            adv_min = '0;
            wrap    = 1'b1;
          end
        end
      end
    end
  end

  // Outputs default to the advanced live count; state branches override for lap freeze and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ss_q    <= 1'b0;
      clr_q   <= 1'b0;
      presc   <= '0;
      cs      <= '0;
      sec     <= '0;
      min     <= '0;
      sms     <= '0;
      s       <= '0;
      m       <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q   <= 1'b0;
      lap_cs  <= '0;
      lap_sec <= '0;
      lap_min <= '0;
      lap_act <= 1'b0;
`endif
    end else begin
      ss_q  <= ss;
      clr_q <= clr;
`ifdef STOPWATCH_LAP_EN
      lap_q <= lap;
`endif
      if (counting) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      cs  <= adv_cs;
      sec <= adv_sec;
      min <= adv_min;
      sms <= adv_cs;
      s   <= adv_sec;
      m   <= adv_min;
      ovf <= wrap;

      case (state)
        IDLE: begin
          if (do_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        RUN: begin
          if (do_ss) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
`ifdef STOPWATCH_LAP_EN
          // The lap snapshot is the pre-tick value even when a tick lands on this edge.
          else if (do_lap) begin
            state   <= LAP;
            lap_act <= 1'b1;
            lap_cs  <= cs;
            lap_sec <= sec;
            lap_min <= min;
            sms     <= cs;
            s       <= sec;
            m       <= min;
          end
`endif
        end

`ifdef STOPWATCH_LAP_EN
        LAP: begin
          if (do_ss) begin
            state   <= PAUSE;
            running <= 1'b0;
            lap_act <= 1'b0;
          end else if (do_lap) begin
            state   <= RUN;
            lap_act <= 1'b0;
          end else begin
            sms <= lap_cs;
            s   <= lap_sec;
            m   <= lap_min;
          end
        end
`endif

        PAUSE: begin
          if (do_clr) begin
            state <= IDLE;
            presc <= '0;
            cs    <= '0;
            sec   <= '0;
            min   <= '0;
            sms   <= '0;
            s     <= '0;
            m     <= '0;
          end else if (do_ss) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed checks of stopwatch_core built with TICK_DIV=4.
// The lap scenario follows STOPWATCH_LAP_EN so it matches whichever RTL build is compiled.
module tb_stopwatch_core;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss    = 1'b0;
  logic       clr   = 1'b0;
  logic       lap   = 1'b0;
  logic [6:0] sms, s, m;
  logic       running, lap_act, ovf;
  int         checks = 0;
  int         passes = 0;

  stopwatch_core #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ss(ss), .clr(clr), .lap(lap),
    .sms(sms), .s(s), .m(m), .running(running), .lap_act(lap_act), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on falling edges.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    cycles(2);
    checks++; if ({m, s, sms} !== 21'd0) $display("[TB] FAIL reset_count: got %0d:%0d.%0d want 0:0.0", m, s, sms); else passes++;
    checks++; if ({running, lap_act, ovf} !== 3'b000) $display("[TB] FAIL reset_flags: got run=%b lap=%b ovf=%b want 000", running, lap_act, ovf); else passes++;
    rst_n = 1'b1;
    cycles(3);
    checks++; if ({running, m, s, sms} !== 22'd0) $display("[TB] FAIL reset_idle: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
  endtask

  task automatic test_start_latency;
    ss = 1'b1; cycles(1); ss = 1'b0;
    checks++; if ({running, sms} !== {1'b1, 7'd0}) $display("[TB] FAIL start_run: got run=%b sms=%0d want 1 0", running, sms); else passes++;
    cycles(3);
    checks++; if (sms !== 7'd0) $display("[TB] FAIL start_early: got sms=%0d want 0", sms); else passes++;
    cycles(1);
    checks++; if (sms !== 7'd1) $display("[TB] FAIL start_first_tick: got sms=%0d want 1", sms); else passes++;
    cycles(395);
    checks++; if ({s, sms} !== {7'd0, 7'd99}) $display("[TB] FAIL start_99: got %0d.%0d want 0.99", s, sms); else passes++;
    cycles(1);
    checks++; if ({s, sms} !== {7'd1, 7'd0}) $display("[TB] FAIL start_1s: got %0d.%0d want 1.0", s, sms); else passes++;
  endtask

  task automatic test_reset_mid;
    cycles(868);
    checks++; if ({m, s, sms} !== {7'd0, 7'd3, 7'd17}) $display("[TB] FAIL mid_count: got %0d:%0d.%0d want 0:3.17", m, s, sms); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({running, ovf, m, s, sms} !== 23'd0) $display("[TB] FAIL mid_async: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
    @(negedge clk); rst_n = 1'b1;
    cycles(10);
    checks++; if ({running, m, s, sms} !== 22'd0) $display("[TB] FAIL mid_idle: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
  endtask

  task automatic test_pause_resume;
    int bad;
    ss = 1'b1; cycles(1); ss = 1'b0;
    cycles(20);
    checks++; if (sms !== 7'd5) $display("[TB] FAIL pause_pre: got sms=%0d want 5", sms); else passes++;
    cycles(1);
    ss = 1'b1; cycles(1); ss = 1'b0;
    checks++; if ({running, sms} !== {1'b0, 7'd5}) $display("[TB] FAIL pause_enter: got run=%b sms=%0d want 0 5", running, sms); else passes++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (sms !== 7'd5 || running !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("[TB] FAIL pause_hold: got %0d changed cycles want 0", bad); else passes++;
    ss = 1'b1; cycles(1); ss = 1'b0;
    checks++; if ({running, sms} !== {1'b1, 7'd5}) $display("[TB] FAIL resume_run: got run=%b sms=%0d want 1 5", running, sms); else passes++;
    cycles(1);
    checks++; if (sms !== 7'd5) $display("[TB] FAIL resume_early: got sms=%0d want 5", sms); else passes++;
    cycles(1);
    checks++; if (sms !== 7'd6) $display("[TB] FAIL resume_tick: got sms=%0d want 6", sms); else passes++;
    clr = 1'b1; cycles(1); clr = 1'b0;
    checks++; if (running !== 1'b1) $display("[TB] FAIL clr_in_run: got run=%b want 1", running); else passes++;
    cycles(3);
    checks++; if (sms !== 7'd7) $display("[TB] FAIL clr_in_run_count: got sms=%0d want 7", sms); else passes++;
    ss = 1'b1; cycles(1); ss = 1'b0;
    checks++; if ({running, sms} !== {1'b0, 7'd7}) $display("[TB] FAIL stop_again: got run=%b sms=%0d want 0 7", running, sms); else passes++;
    clr = 1'b1; cycles(1); clr = 1'b0;
    checks++; if ({running, m, s, sms} !== 22'd0) $display("[TB] FAIL clear: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
    cycles(10);
    checks++; if ({running, sms} !== 8'd0) $display("[TB] FAIL clear_idle: got run=%b sms=%0d want 0 0", running, sms); else passes++;
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap;
    ss = 1'b1; cycles(1); ss = 1'b0;
    cycles(492);
    checks++; if ({lap_act, s, sms} !== {1'b0, 7'd1, 7'd23}) $display("[TB] FAIL lap_pre: got lap=%b %0d.%0d want 0 1.23", lap_act, s, sms); else passes++;
    lap = 1'b1; cycles(1); lap = 1'b0;
    checks++; if ({lap_act, s, sms} !== {1'b1, 7'd1, 7'd23}) $display("[TB] FAIL lap_enter: got lap=%b %0d.%0d want 1 1.23", lap_act, s, sms); else passes++;
    cycles(207);
    checks++; if ({running, lap_act, s, sms} !== {2'b11, 7'd1, 7'd23}) $display("[TB] FAIL lap_frozen: got run=%b lap=%b %0d.%0d want 1 1 1.23", running, lap_act, s, sms); else passes++;
    cycles(100);
    lap = 1'b1; cycles(1); lap = 1'b0;
    checks++; if ({lap_act, s, sms} !== {1'b0, 7'd2, 7'd0}) $display("[TB] FAIL lap_exit: got lap=%b %0d.%0d want 0 2.0", lap_act, s, sms); else passes++;
    ss = 1'b1; cycles(1); ss = 1'b0;
    clr = 1'b1; cycles(1); clr = 1'b0;
    checks++; if ({running, lap_act, m, s, sms} !== 23'd0) $display("[TB] FAIL lap_clear: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
  endtask
`else
  task automatic test_lap;
    ss = 1'b1; cycles(1); ss = 1'b0;
    cycles(8);
    checks++; if (sms !== 7'd2) $display("[TB] FAIL nolap_pre: got sms=%0d want 2", sms); else passes++;
    lap = 1'b1; cycles(1); lap = 1'b0;
    checks++; if ({running, lap_act} !== 2'b10) $display("[TB] FAIL nolap_flags: got run=%b lap=%b want 1 0", running, lap_act); else passes++;
    cycles(3);
    checks++; if (sms !== 7'd3) $display("[TB] FAIL nolap_live: got sms=%0d want 3", sms); else passes++;
    ss = 1'b1; cycles(1); ss = 1'b0;
    clr = 1'b1; cycles(1); clr = 1'b0;
  endtask
`endif

  task automatic test_wrap;
    ss = 1'b1; cycles(1); ss = 1'b0;
    cycles(3);
    checks++; if ({ovf, sms} !== 8'd0) $display("[TB] FAIL wrap_pre: got ovf=%b sms=%0d want 0 0", ovf, sms); else passes++;
    force dut.cs  = 7'd99;
    force dut.sec = 7'd59;
    force dut.min = 7'd99;
    #1;
    release dut.cs;
    release dut.sec;
    release dut.min;
    cycles(1);
    checks++; if ({m, s, sms} !== 21'd0) $display("[TB] FAIL wrap_count: got %0d:%0d.%0d want 0:0.0", m, s, sms); else passes++;
    checks++; if ({ovf, running} !== 2'b11) $display("[TB] FAIL wrap_ovf: got ovf=%b run=%b want 1 1", ovf, running); else passes++;
    cycles(1);
    checks++; if ({ovf, running} !== 2'b01) $display("[TB] FAIL wrap_ovf_clear: got ovf=%b run=%b want 0 1", ovf, running); else passes++;
    cycles(3);
    checks++; if ({m, s, sms} !== {7'd0, 7'd0, 7'd1}) $display("[TB] FAIL wrap_continue: got %0d:%0d.%0d want 0:0.1", m, s, sms); else passes++;
    ss = 1'b1; cycles(1); ss = 1'b0;
    clr = 1'b1; cycles(1); clr = 1'b0;
  endtask

  task automatic test_priority;
    ss = 1'b1; cycles(1); ss = 1'b0;
    cycles(8);
    ss = 1'b1; cycles(1); ss = 1'b0;
    checks++; if ({running, sms} !== {1'b0, 7'd2}) $display("[TB] FAIL prio_pause: got run=%b sms=%0d want 0 2", running, sms); else passes++;
    cycles(2);
    ss = 1'b1; clr = 1'b1; cycles(1); clr = 1'b0;
    checks++; if ({running, m, s, sms} !== 22'd0) $display("[TB] FAIL prio_clr_wins: got run=%b %0d:%0d.%0d want 0 0:0.0", running, m, s, sms); else passes++;
    cycles(5);
    checks++; if ({running, sms} !== 8'd0) $display("[TB] FAIL prio_held_ss: got run=%b sms=%0d want 0 0", running, sms); else passes++;
    ss = 1'b0;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_reset_mid();
    test_pause_resume();
    test_lap();
    test_wrap();
    test_priority();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
